// File: rtl/mc_pkg.sv
// Shared encodings for the multicycle controller: states, opcodes, function fields, ALU codes.
// Pure constants and types; no logic.
package mc_pkg;

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        EXEC_R   = 4'd2,
        R_WB     = 4'd3,
        MEM_ADDR = 4'd4,
        MEM_RD   = 4'd5,
        MEM_WB   = 4'd6,
        MEM_WR   = 4'd7,
        BRANCH   = 4'd8,
        JUMP     = 4'd9,
        IMM_EX   = 4'd10,
        IMM_WB   = 4'd11,
        ILLEGAL  = 4'd12,
        TRAP     = 4'd13
    } state_e;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ORI   = 6'b001101;

    localparam logic [5:0] FN_ADD  = 6'b100000;
    localparam logic [5:0] FN_SUB  = 6'b100010;
    localparam logic [5:0] FN_AND  = 6'b100100;
    localparam logic [5:0] FN_OR   = 6'b100101;
    localparam logic [5:0] FN_ASR  = 6'b101010;
    localparam logic [5:0] FN_SLLV = 6'b000100;
    localparam logic [5:0] FN_NOP  = 6'b000000;

    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_OR   = 4'b0001;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_SUB  = 4'b0011;
    localparam logic [3:0] ALU_SLLV = 4'b1001;
    localparam logic [3:0] ALU_ASR  = 4'b1010;

endpackage

// File: rtl/alu_func_decoder.sv
// R-type function field to ALU select; func_vld flags a recognised function.
// Latency: combinational; backpressure: none.
module alu_func_decoder
    import mc_pkg::*;
#(
    parameter int FUNC_W    = 6,
    parameter int ALU_SEL_W = 4
) (
    input  logic [FUNC_W-1:0]    func,
    output logic [ALU_SEL_W-1:0] alu_sel,
    output logic                 func_vld
);

    always_comb begin
        alu_sel  = '0;
        func_vld = 1'b1;
        case (func)
            FUNC_W'(FN_ADD):  alu_sel = ALU_SEL_W'(ALU_ADD);
            FUNC_W'(FN_SUB):  alu_sel = ALU_SEL_W'(ALU_SUB);
            FUNC_W'(FN_AND):  alu_sel = ALU_SEL_W'(ALU_AND);
            FUNC_W'(FN_OR):   alu_sel = ALU_SEL_W'(ALU_OR);
            FUNC_W'(FN_ASR):  alu_sel = ALU_SEL_W'(ALU_ASR);
            // the all-zero NOP encoding runs harmlessly through the variable shifter
            FUNC_W'(FN_SLLV),
            FUNC_W'(FN_NOP):  alu_sel = ALU_SEL_W'(ALU_SLLV);
            default:          func_vld = 1'b0;
        endcase
    end

endmodule

// File: rtl/mc_control_fsm.sv
// Multicycle CPU control FSM with memory-wait timeout trap; Moore outputs plus mem_ready strobes.
// Latency: 3-5 cycles per instruction with ready memory; backpressure: stalls in mem_req states on mem_ready.
module mc_control_fsm
    import mc_pkg::*;
#(
    parameter int OP_W      = 6,
    parameter int FUNC_W    = 6,
    parameter int ALU_SEL_W = 4,
    parameter int TIMEOUT   = 15
) (
    input  logic                 CLK,
    input  logic                 RST_N,
    input  logic [OP_W-1:0]      Op,
    input  logic [FUNC_W-1:0]    func,
    input  logic                 mem_ready,
    output logic                 mem_req,
    output logic                 MtoRFsel,
    output logic                 RFDSel,
    output logic                 IDSel,
    output logic                 ALU_In_sel,
    output logic [1:0]           PCSel,
    output logic [1:0]           ALU_In2_sel,
    output logic                 IRWE,
    output logic                 DMWE,
    output logic                 RFWE,
    output logic                 PC_write,
    output logic                 branch,
    output logic                 jump,
    output logic [ALU_SEL_W-1:0] ALU_sel,
    output logic                 illegal,
    output logic                 trap
);

    state_e                state_q, state_d;
    logic [OP_W-1:0]       op_q, op_d;
    logic [ALU_SEL_W-1:0]  alu_r_q, alu_r_d;
    logic [7:0]            cnt_q, cnt_d;
    logic [ALU_SEL_W-1:0]  dec_alu;
    logic                  dec_vld;
    logic                  mem_wait;
    logic                  timeout_hit;

    alu_func_decoder #(
        .FUNC_W    (FUNC_W),
        .ALU_SEL_W (ALU_SEL_W)
    ) u_alu_func_decoder (
        .func     (func),
        .alu_sel  (dec_alu),
        .func_vld (dec_vld)
    );

    assign mem_wait    = ((state_q == FETCH) || (state_q == MEM_RD) || (state_q == MEM_WR)) && !mem_ready;
    assign timeout_hit = (({1'b0, cnt_q} + 9'd1) == 9'(TIMEOUT));

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= FETCH;
            op_q    <= '0;
            alu_r_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            alu_r_q <= alu_r_d;
            cnt_q   <= cnt_d;
        end
    end

    // Op/func are captured only in DECODE so later states are immune to IR changes
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        alu_r_d = alu_r_q;
        cnt_d   = '0;
        case (state_q)
            FETCH:    if (mem_ready) state_d = DECODE;
            DECODE: begin
                op_d    = Op;
                alu_r_d = dec_alu;
                case (Op)
                    OP_W'(OP_RTYPE):           state_d = dec_vld ? EXEC_R : ILLEGAL;
                    OP_W'(OP_LW), OP_W'(OP_SW):    state_d = MEM_ADDR;
                    OP_W'(OP_BEQ), OP_W'(OP_BNE):  state_d = BRANCH;
                    OP_W'(OP_J):               state_d = JUMP;
                    OP_W'(OP_ADDI), OP_W'(OP_ORI): state_d = IMM_EX;
                    default:                   state_d = ILLEGAL;
                endcase
            end
            EXEC_R:   state_d = R_WB;
            MEM_ADDR: state_d = (op_q == OP_W'(OP_LW)) ? MEM_RD : MEM_WR;
            MEM_RD:   if (mem_ready) state_d = MEM_WB;
            MEM_WR:   if (mem_ready) state_d = FETCH;
            IMM_EX:   state_d = IMM_WB;
            TRAP:     state_d = TRAP;
            default:  state_d = FETCH;
        endcase
        // completion wins over timeout because mem_wait already excludes mem_ready
        if (mem_wait) begin
            cnt_d = cnt_q + 8'd1;
            if (timeout_hit) state_d = TRAP;
        end
    end

    always_comb begin
        mem_req     = 1'b0;
        MtoRFsel    = 1'b0;
        RFDSel      = 1'b0;
        IDSel       = 1'b0;
        ALU_In_sel  = 1'b0;
        PCSel       = 2'b00;
        ALU_In2_sel = 2'b00;
        IRWE        = 1'b0;
        DMWE        = 1'b0;
        RFWE        = 1'b0;
        PC_write    = 1'b0;
        branch      = 1'b0;
        jump        = 1'b0;
        ALU_sel     = '0;
        illegal     = 1'b0;
        trap        = 1'b0;
        if (!RST_N) begin
            ALU_sel = ALU_SEL_W'(ALU_ADD);
        end else begin
            case (state_q)
                FETCH: begin
                    mem_req     = 1'b1;
                    ALU_In2_sel = 2'b01;
                    ALU_sel     = ALU_SEL_W'(ALU_ADD);
                    IRWE        = mem_ready;
                    PC_write    = mem_ready;
                end
                EXEC_R: begin
                    ALU_In_sel = 1'b1;
                    ALU_sel    = alu_r_q;
                end
                R_WB: begin
                    RFWE   = 1'b1;
                    RFDSel = 1'b1;
                end
                MEM_ADDR: begin
                    ALU_In_sel  = 1'b1;
                    ALU_In2_sel = 2'b10;
                    ALU_sel     = ALU_SEL_W'(ALU_ADD);
                end
                MEM_RD: begin
                    IDSel   = 1'b1;
                    mem_req = 1'b1;
                end
                MEM_WB: begin
                    RFWE     = 1'b1;
                    MtoRFsel = 1'b1;
                end
                MEM_WR: begin
                    IDSel   = 1'b1;
                    mem_req = 1'b1;
                    DMWE    = mem_ready;
                end
                BRANCH: begin
                    ALU_In_sel = 1'b1;
                    ALU_sel    = ALU_SEL_W'(ALU_SUB);
                    PCSel      = 2'b01;
                    branch     = 1'b1;
                    jump       = (op_q == OP_W'(OP_BNE));
                end
                JUMP: begin
                    PCSel    = 2'b10;
                    PC_write = 1'b1;
                end
                IMM_EX: begin
                    ALU_In_sel  = 1'b1;
                    ALU_In2_sel = 2'b10;
                    ALU_sel     = (op_q == OP_W'(OP_ORI)) ? ALU_SEL_W'(ALU_OR) : ALU_SEL_W'(ALU_ADD);
                end
                IMM_WB:   RFWE    = 1'b1;
                ILLEGAL:  illegal = 1'b1;
                TRAP:     trap    = 1'b1;
                default: ;
            endcase
        end
    end

endmodule
